// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 round-constant path: controller state
// encoding and default round/latency parameters.
package sha256_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE,
        WAIT_BLK
    } state_t;

    localparam int unsigned K_LENGTH_DEFAULT   = 64;
    localparam int unsigned K_PIPE_LAT_DEFAULT = 2;

endpackage

// File: rtl/round_valid_delay.sv
// Fixed-depth shift register that carries a round strobe and its index
// alongside the K constant pipeline; cleared synchronously by reset.
module round_valid_delay #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] tail
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one stage per clock; reset flushes every stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= head;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tail = stage[DEPTH-1];

endmodule

// File: rtl/k_round_controller.sv
// Round-address sequencer for the K constant ROM / K-vector stage.
// Optional multi-block chaining is enabled with `define SHA_MULTIBLOCK_EN.
module k_round_controller
    import sha256_pkg::*;
#(
    parameter  int unsigned K_LENGTH   = K_LENGTH_DEFAULT,
    parameter  int unsigned K_PIPE_LAT = K_PIPE_LAT_DEFAULT,
    localparam int unsigned AW         = $clog2(K_LENGTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          last_block,
    output logic          k_enable,
    output logic [AW-1:0] k_address,
    output logic          address_read_complete,
    output logic          round_valid,
    output logic [AW-1:0] round_index,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(K_LENGTH - 1);
    localparam logic [AW-1:0] PREV_ADDR = AW'(K_LENGTH - 2);
    localparam int unsigned   CW        = (K_PIPE_LAT > 1) ? $clog2(K_PIPE_LAT) : 1;
    localparam logic [CW-1:0] DRAIN_END = CW'(K_PIPE_LAT - 1);

    state_t        state;
    logic [CW-1:0] drain_cnt;
    logic [AW:0]   pipe_head;
    logic [AW:0]   pipe_tail;

`ifdef SHA_MULTIBLOCK_EN
    logic last_q;
`else
    logic unused_last_block;
    assign unused_last_block = last_block;
`endif

    // Controller FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state                 <= IDLE;
            drain_cnt             <= '0;
            k_enable              <= 1'b0;
            k_address             <= '0;
            address_read_complete <= 1'b0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
`ifdef SHA_MULTIBLOCK_EN
            last_q                <= 1'b0;
`endif
        end else begin
            address_read_complete <= 1'b0;
            done                  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= ISSUE;
                        k_enable  <= 1'b1;
                        k_address <= '0;
                        busy      <= 1'b1;
`ifdef SHA_MULTIBLOCK_EN
                        last_q    <= last_block;
`endif
                    end
                end
                ISSUE: begin
                    if (k_address == LAST_ADDR) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        k_address             <= k_address + AW'(1);
                        // pulse lands in the same cycle the last address is shown
                        address_read_complete <= (k_address == PREV_ADDR);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_END) begin
`ifdef SHA_MULTIBLOCK_EN
                        if (!last_q) begin
                            state <= WAIT_BLK;
                        end else begin
                            state     <= DONE;
                            k_enable  <= 1'b0;
                            k_address <= '0;
                            done      <= 1'b1;
                        end
`else
                        state     <= DONE;
                        k_enable  <= 1'b0;
                        k_address <= '0;
                        done      <= 1'b1;
`endif
                    end else begin
                        drain_cnt <= drain_cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
`ifdef SHA_MULTIBLOCK_EN
                WAIT_BLK: begin
                    if (start) begin
                        state     <= ISSUE;
                        k_address <= '0;
                        last_q    <= last_block;
                    end
                end
`endif
                default: begin
                    state     <= IDLE;
                    k_enable  <= 1'b0;
                    k_address <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Index is zeroed at the head so round_index is 0 whenever round_valid is 0.
    assign pipe_head = (state == ISSUE) ? {1'b1, k_address} : '0;

    round_valid_delay #(
        .DEPTH (K_PIPE_LAT),
        .WIDTH (AW + 1)
    ) u_delay (
        .clock (clock),
        .reset (reset),
        .head  (pipe_head),
        .tail  (pipe_tail)
    );

    assign round_valid = pipe_tail[AW];
    assign round_index = pipe_tail[AW-1:0];

endmodule
